// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction ROM address and
// buffers fetched {pc, instr} pairs in a prefetch FIFO for decode.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [31:0]                imem_addr,
  input  logic [31:0]                imem_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_instr,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_ent_t;

  fetch_ent_t        mem [DEPTH];
  fetch_ent_t        head;
  logic [31:0]       fetch_pc;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic              pop;
  logic              push;

  assign imem_addr  = fetch_pc;
  assign fifo_count = count;
  assign out_valid  = (count != '0);

  // A redirect suppresses the pop so the head is never consumed on a flush.
  assign pop  = out_valid & out_ready & ~redirect_valid;
  assign push = ~redirect_valid & ((count < FULL) | pop);

  assign head      = mem[rd_ptr];
  assign out_pc    = out_valid ? head.pc    : 32'h0;
  assign out_instr = out_valid ? head.instr : 32'h0;

  // Storage carries no reset; outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{pc: fetch_pc, instr: imem_data};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + 32'd4;
        wr_ptr   <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: queue-based fetch model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_instr_fetch_unit;

  localparam int DEPTH = 2;
  localparam logic [31:0] RPC = 32'h0;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [1:0]  fifo_count;

  int checks;
  int failures;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        q[$];
  logic [31:0] mpc;
  bit          cmp_en;

  instr_fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fifo_count     (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return a >> 2;
  endfunction

  assign imem_data = rom(imem_addr);

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mpc = RPC;
  endtask

  // Fetch rules applied to the inputs present at a clock edge.
  task automatic model_step();
    bit do_pop;
    bit do_push;
    if (redirect_valid) begin
      q.delete();
      mpc = redirect_pc & ~32'h3;
    end else begin
      do_pop  = (q.size() > 0) && out_ready;
      do_push = (q.size() < DEPTH) || do_pop;
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back('{pc: mpc, instr: rom(mpc)});
        mpc = mpc + 32'd4;
      end
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      chk("m_imem_addr", imem_addr, mpc);
      chk("m_out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
      chk("m_fifo_count", {30'b0, fifo_count}, q.size());
      chk("m_out_pc", out_pc, (q.size() != 0) ? q[0].pc : 32'h0);
      chk("m_out_instr", out_instr, (q.size() != 0) ? q[0].instr : 32'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    if (!reset) model_step();
    #1;
  endtask

  task automatic rst_pulse();
    reset = 1'b1;
    #1;
    chk("async_valid", {31'b0, out_valid}, 32'h0);
    chk("async_count", {30'b0, fifo_count}, 32'h0);
    chk("async_addr", imem_addr, RPC);
    chk("async_pc", out_pc, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    cmp_en = 1'b0;
    reset = 1'b1;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    reset = 1'b0;
    out_ready = 1'b1;

    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_instr", out_instr, 32'h0);
    tick();
    chk("s1_valid", {31'b0, out_valid}, 32'h1);
    chk("s1_pc0", out_pc, 32'h0);
    chk("s1_addr4", imem_addr, 32'h4);
    tick();
    chk("s1_pc4", out_pc, 32'h4);
    chk("s1_instr1", out_instr, 32'h1);
    tick();
    chk("s1_pc8", out_pc, 32'h8);

    out_ready = 1'b0;
    rst_pulse();
    repeat (5) tick();
    chk("s2_count", {30'b0, fifo_count}, 32'h2);
    chk("s2_addr", imem_addr, 32'h8);
    chk("s2_head", out_pc, 32'h0);
    out_ready = 1'b1;
    tick();
    chk("s2_pc4", out_pc, 32'h4);
    chk("s2_cnt_keep", {30'b0, fifo_count}, 32'h2);
    chk("s2_addr12", imem_addr, 32'hC);
    tick();
    chk("s2_pc8", out_pc, 32'h8);

    out_ready = 1'b0;
    repeat (2) tick();
    chk("s3_full", {30'b0, fifo_count}, 32'h2);
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h34;
    tick();
    redirect_valid = 1'b0;
    chk("s3_valid0", {31'b0, out_valid}, 32'h0);
    chk("s3_count0", {30'b0, fifo_count}, 32'h0);
    chk("s3_addr", imem_addr, 32'h34);
    tick();
    chk("s3_pc", out_pc, 32'h34);
    chk("s3_instr", out_instr, 32'hD);

    redirect_valid = 1'b1;
    redirect_pc = 32'h37;
    tick();
    chk("s4_align", imem_addr, 32'h34);
    redirect_pc = 32'h100;
    tick();
    redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    chk("s4_last_wins", imem_addr, 32'h200);
    tick();
    chk("s4_pc", out_pc, 32'h200);

    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("s5_top", out_pc, 32'hFFFF_FFFC);
    chk("s5_addr_wrap", imem_addr, 32'h0);
    tick();
    chk("s5_wrap_pc", out_pc, 32'h0);

    for (int i = 0; i < 30; i++) begin
      out_ready = (i % 3) != 0;
      redirect_valid = (i == 11) || (i == 12) || (i == 23);
      redirect_pc = (i == 23) ? 32'h81 : 32'h40 + 32'(i);
      tick();
    end
    redirect_valid = 1'b0;

    out_ready = 1'b0;
    repeat (3) tick();
    chk("s7_full", {30'b0, fifo_count}, 32'h2);
    rst_pulse();
    out_ready = 1'b1;
    tick();
    chk("s7_restart", out_pc, RPC);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
